// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and defaults for the UART transmit arbiter
// Contents: arbiter state encoding, UART word size, default watchdog limit.
package uart_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH0, S_LAUNCH1, S_BUSY, S_ACK} arb_state_t;
   localparam int UART_WORDSIZE = 8;
   localparam int UART_BIT_SIZE = 10417;
   // a frame is 10 bit times; rounding up to the next all-ones value gives margin
   localparam int UART_ARB_TIMEOUT = (1 << $clog2(UART_BIT_SIZE * 10)) - 1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick starting after the last winner
// Ports: req (request vector), last (previous winner), winner (index), valid (any request).
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] winner,
   output logic         valid
);
   logic [W-1:0] idx;
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N; i++) begin
         idx = W'((int'(last) + i) % N);
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one UART serializer among NUM_REQ byte producers
// Ports: clk; rst (async, active-low); req/req_data from producers; ack one-hot done pulse;
//        busy, grant_id status; uart_data/uart_ready to serializer, uart_tx_done from it;
//        timeout_err watchdog pulse, live only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int WORDSIZE = UART_WORDSIZE,
   parameter int TIMEOUT  = UART_ARB_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*WORDSIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic [WORDSIZE-1:0]           uart_data,
   output logic                          uart_ready,
   input  logic                          uart_tx_done,
   output logic                          timeout_err
);
   localparam int IW = $clog2(NUM_REQ);
   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
      $error("uart_tx_arb: NUM_REQ must be 2..16 and TIMEOUT positive");
   end
   arb_state_t state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, last_q, last_d, win;
   logic [WORDSIZE-1:0] data_q, data_d;
   logic [WORDSIZE-1:0] req_bytes [NUM_REQ];
   logic win_valid, tmo;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[i*WORDSIZE +: WORDSIZE];
   end
   rr_arbiter #(.N(NUM_REQ), .W(IW)) u_rr (
      .req    (req),
      .last   (last_q),
      .winner (win),
      .valid  (win_valid)
   );
`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // held at zero outside a grant, so it is clear on entry to LAUNCH0
   always_comb cnt_d = (state_q == S_IDLE) ? '0 : (state_q == S_BUSY) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   assign tmo = (state_q == S_BUSY) && (cnt_q == CW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE:
            if (win_valid) begin
               state_d = S_LAUNCH0;
               grant_d = win;
               last_d  = win;
               data_d  = req_bytes[win];
            end
         S_LAUNCH0: state_d = S_LAUNCH1;
         S_LAUNCH1: state_d = S_BUSY;
         // a done in the expiry cycle still counts as a normal completion
         S_BUSY:    state_d = uart_tx_done ? S_ACK : tmo ? S_IDLE : S_BUSY;
         S_ACK:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end
   always_comb begin
      uart_ready  = (state_q == S_LAUNCH0) || (state_q == S_LAUNCH1);
      busy        = state_q != S_IDLE;
      ack         = (state_q == S_ACK) ? NUM_REQ'(1) << grant_q : '0;
      timeout_err = tmo && !uart_tx_done;
      grant_id    = grant_q;
      uart_data   = data_q;
   end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb with a behavioural serializer
module tb_uart_tx_arb;
   localparam int BITC = 4;
   logic clk = 1'b0;
   logic rst, ser_rst_n, ser_mute;
   logic [3:0] req;
   logic [31:0] req_data;
   logic [3:0] ack;
   logic busy, uart_ready, uart_tx_done, timeout_err, tx;
   logic [1:0] grant_id;
   logic [7:0] uart_data;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   uart_tx_arb #(.NUM_REQ(4), .WORDSIZE(8), .TIMEOUT(50)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .ack          (ack),
      .busy         (busy),
      .grant_id     (grant_id),
      .uart_data    (uart_data),
      .uart_ready   (uart_ready),
      .uart_tx_done (uart_tx_done),
      .timeout_err  (timeout_err)
   );
   typedef enum logic [1:0] {M_INIT, M_WAIT, M_SEND, M_DONE} mst_t;
   mst_t m_st;
   logic [7:0] m_byte;
   logic [7:0] last_sent = 8'h00;
   int m_cnt = 0;
   int frames = 0;
   always @(posedge clk or negedge ser_rst_n)
      if (!ser_rst_n) begin
         m_st  <= M_INIT;
         m_cnt <= 0;
      end else
         case (m_st)
            M_INIT: m_st <= M_WAIT;
            M_WAIT:
               if (uart_ready) begin
                  m_st      <= M_SEND;
                  m_byte    <= uart_data;
                  m_cnt     <= 0;
                  frames    <= frames + 1;
                  last_sent <= uart_data;
               end
            M_SEND:
               if (m_cnt == BITC * 10 - 1) m_st <= M_DONE;
               else m_cnt <= m_cnt + 1;
            default: m_st <= M_WAIT;
         endcase
   assign tx = (m_st != M_SEND) ? 1'b1 : (m_cnt / BITC == 0) ? 1'b0 :
               (m_cnt / BITC == 9) ? 1'b1 : m_byte[3'(m_cnt / BITC - 1)];
   assign uart_tx_done = (m_st == M_DONE) && !ser_mute;

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (uart_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = (uart_ready === 1'b1);
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (uart_tx_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = (uart_tx_done === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b0; ser_rst_n = 1'b0; ser_mute = 1'b0; req = '0; req_data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ack, busy, uart_ready, timeout_err} !== 7'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b want=0000000", {ack, busy, uart_ready, timeout_err});
      end
      checks++;
      if ({grant_id, uart_data} !== 10'b0) begin
         failures++; $display("FAIL reset_data got=%h want=000", {grant_id, uart_data});
      end
      rst = 1'b1; ser_rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_single();
      bit ok;
      logic [7:0] rx = '0;
      req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if ({uart_ready, busy, grant_id, uart_data} !== {1'b1, 1'b1, 2'd1, 8'hA5}) begin
         failures++; $display("FAIL single_launch0 got=%h want=%h", {uart_ready, busy, grant_id, uart_data}, {1'b1, 1'b1, 2'd1, 8'hA5});
      end
      @(negedge clk);
      checks++;
      if (uart_ready !== 1'b1) begin failures++; $display("FAIL single_launch1 got=%b want=1", uart_ready); end
      @(negedge clk);
      checks++;
      if ({uart_ready, busy, uart_data, tx} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
         failures++; $display("FAIL single_busy got=%h want=%h", {uart_ready, busy, uart_data, tx}, {1'b0, 1'b1, 8'hA5, 1'b0});
      end
      for (int i = 0; i < 8; i++) begin
         repeat (BITC) @(negedge clk);
         rx = {tx, rx[7:1]};
      end
      checks++;
      if (rx !== 8'hA5) begin failures++; $display("FAIL single_serial got=%h want=a5", rx); end
      wait_done(ok);
      checks++;
      if (!ok || ack !== 4'b0) begin failures++; $display("FAIL single_done got=%b/%b want=1/0000", ok, ack); end
      @(negedge clk);
      checks++;
      if (ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b want=0010", ack); end
      req = '0;
      @(negedge clk);
      checks++;
      if ({ack, busy} !== 5'b0) begin failures++; $display("FAIL single_after got=%b want=00000", {ack, busy}); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int base;
      int order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] b;
      rst = 1'b0;
      req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req = 4'b1111;
      @(negedge clk);
      rst = 1'b1;
      base = frames;
      for (int g = 0; g < 5; g++) begin
         b = 8'(req_data >> (8 * order[g]));
         wait_ready(ok);
         checks++;
         if (!ok || grant_id !== 2'(order[g]) || uart_data !== b) begin
            failures++; $display("FAIL rr_grant%0d got=%0d/%h want=%0d/%h", g, grant_id, uart_data, order[g], b);
         end
         @(negedge clk);
         wait_done(ok);
         @(negedge clk);
         checks++;
         if (!ok || ack !== 4'(1 << order[g])) begin
            failures++; $display("FAIL rr_ack%0d got=%b want=%b", g, ack, 4'(1 << order[g]));
         end
         checks++;
         if (frames != base + g + 1 || last_sent !== b) begin
            failures++; $display("FAIL rr_frames%0d got=%0d/%h want=%0d/%h", g, frames - base, last_sent, g + 1, b);
         end
         if (g == 4) req = '0;
         @(negedge clk);
         checks++;
         if (uart_ready !== 1'b0) begin failures++; $display("FAIL rr_gap%0d got=%b want=0", g, uart_ready); end
         @(negedge clk);
         checks++;
         if (uart_ready !== (g < 4)) begin failures++; $display("FAIL rr_next%0d got=%b want=%b", g, uart_ready, g < 4); end
      end
   endtask

   task automatic test_drop();
      bit ok;
      req_data = {8'hC3, 8'h3C, 8'h00, 8'h00};
      req = 4'b1100;
      wait_ready(ok);
      checks++;
      if (!ok || grant_id !== 2'd2) begin failures++; $display("FAIL drop_grant got=%0d want=2", grant_id); end
      repeat (5) @(negedge clk);
      req = 4'b1000;
      wait_done(ok);
      @(negedge clk);
      checks++;
      if (!ok || ack !== 4'b0100) begin failures++; $display("FAIL drop_ack got=%b want=0100", ack); end
      wait_ready(ok);
      checks++;
      if (!ok || grant_id !== 2'd3 || uart_data !== 8'hC3) begin
         failures++; $display("FAIL drop_next got=%0d/%h want=3/c3", grant_id, uart_data);
      end
      @(negedge clk);
      wait_done(ok);
      @(negedge clk);
      checks++;
      if (!ok || ack !== 4'b1000) begin failures++; $display("FAIL drop_ack3 got=%b want=1000", ack); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bit ok;
      req_data = {8'h00, 8'h00, 8'h99, 8'h5A};
      req = 4'b0001;
      wait_ready(ok);
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b want=1", busy); end
      rst = 1'b0; ser_rst_n = 1'b0;
      #1;
      checks++;
      if ({ack, busy, uart_ready, timeout_err, grant_id, uart_data} !== 17'b0) begin
         failures++; $display("FAIL mid_reset got=%h want=0", {ack, busy, uart_ready, timeout_err, grant_id, uart_data});
      end
      @(negedge clk);
      rst = 1'b1; ser_rst_n = 1'b1; req = 4'b0011;
      wait_ready(ok);
      checks++;
      if (!ok || grant_id !== 2'd0 || uart_data !== 8'h5A) begin
         failures++; $display("FAIL mid_regrant got=%0d/%h want=0/5a", grant_id, uart_data);
      end
      @(negedge clk);
      wait_done(ok);
      @(negedge clk);
      checks++;
      if (!ok || ack !== 4'b0001) begin failures++; $display("FAIL mid_ack got=%b want=0001", ack); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_ser_reset();
      bit ok;
      int base;
      rst = 1'b0; ser_rst_n = 1'b0;
      req_data = {24'h0, 8'h77};
      req = 4'b0001;
      @(negedge clk);
      base = frames;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (uart_ready !== 1'b1) begin failures++; $display("FAIL ser_launch0 got=%b want=1", uart_ready); end
      ser_rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (uart_ready !== 1'b1) begin failures++; $display("FAIL ser_launch1 got=%b want=1", uart_ready); end
      wait_done(ok);
      @(negedge clk);
      checks++;
      if (!ok || ack !== 4'b0001) begin failures++; $display("FAIL ser_ack got=%b want=0001", ack); end
      checks++;
      if (frames != base + 1 || last_sent !== 8'h77) begin
         failures++; $display("FAIL ser_frame got=%0d/%h want=1/77", frames - base, last_sent);
      end
      req = '0;
      @(negedge clk);
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      bit early = 1'b0;
      ser_mute = 1'b1;
      req_data = {8'h00, 8'h00, 8'h24, 8'h42};
      req = 4'b0001;
      wait_ready(ok);
      @(negedge clk);
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (n < 50 && (timeout_err !== 1'b0 || ack !== 4'b0)) early = 1'b1;
      end
      checks++;
      if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b want=1", timeout_err); end
      checks++;
      if (early) begin failures++; $display("FAIL tmo_early got=1 want=0"); end
      req = 4'b0011;
      @(negedge clk);
      checks++;
      if ({timeout_err, ack, busy} !== 6'b0) begin
         failures++; $display("FAIL tmo_after got=%b want=000000", {timeout_err, ack, busy});
      end
      ser_mute = 1'b0;
      wait_ready(ok);
      checks++;
      if (!ok || grant_id !== 2'd1) begin failures++; $display("FAIL tmo_next got=%0d want=1", grant_id); end
      @(negedge clk);
      wait_done(ok);
      @(negedge clk);
      checks++;
      if (!ok || ack !== 4'b0010) begin failures++; $display("FAIL tmo_ack got=%b want=0010", ack); end
      req = '0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_mid_reset();
      test_ser_reset();
`ifdef UART_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
